uart_ctrl_axi: RTL
==================

UART_CTRL_AXI -- requirements
Module: uart_ctrl_axi

Interface
REQ-001 SHALL have parameter SYS_FRE, default 100_000_000: constant returned at offset 0x00.
REQ-002 SHALL have parameter ADDR_W, default 12: AXI address width, minimum 8.
REQ-003 SHALL have parameter CNT_W, default 16: FIFO count width, range 1..16.
REQ-004 SHALL have parameter DEF_DIV, default 868: reset value of the baud divisor.
REQ-005 SHALL have port i_s_axi_aclk, in, 1: the single clock.
REQ-006 SHALL have port i_s_axi_aresetn, in, 1: asynchronous active-low reset.
REQ-007 SHALL have ports i_s_axi_awaddr/awvalid, o_s_axi_awready, in/in/out, ADDR_W/1/1: AXI4-lite write-address channel.
REQ-008 SHALL have ports i_s_axi_wdata/wstrb/wvalid, o_s_axi_wready, in/in/in/out, 32/4/1/1: write-data channel.
REQ-009 SHALL have ports o_s_axi_bresp/bvalid, i_s_axi_bready, out/out/in, 2/1/1: write-response channel.
REQ-010 SHALL have ports i_s_axi_araddr/arvalid, o_s_axi_arready, in/in/out, ADDR_W/1/1: read-address channel.
REQ-011 SHALL have ports o_s_axi_rdata/rresp/rvalid, i_s_axi_rready, out/out/out/in, 32/2/1/1: read-data channel.
REQ-012 SHALL have outputs o_module_en 1, o_fifo_clr 1, o_fre_cnt 32, o_uart_data_bit 4, o_uart_parity_mode 3, o_uart_stop_bit 3: UART configuration.
REQ-013 SHALL have outputs o_tx_data 8 and o_tx_valid 1, plus input i_tx_full 1: TX FIFO push.
REQ-014 SHALL have inputs i_rx_data 9 and i_rx_empty 1, plus output o_rx_req 1: RX FIFO pop.
REQ-015 SHALL have inputs i_tx_fifo_wr_cnt CNT_W and i_rx_fifo_rd_cnt CNT_W: FIFO levels.
REQ-016 SHALL have output o_irq, 1: registered, level-high interrupt.

Function
REQ-017 SHALL assert awready and wready independently whenever the respective beat is not yet held and bvalid=0, so AW and W may arrive in either order.
REQ-018 SHALL perform the register write in the cycle after both beats are held, assert bvalid the following cycle, hold bvalid until bready, and accept no new AW or W beat while bvalid=1.
REQ-019 SHALL assert arready only while rvalid=0; rdata/rresp/rvalid SHALL be registered one cycle after the AR handshake and held until rready.
REQ-020 SHALL decode offset addr[7:2] only when addr[ADDR_W-1:8]=0; an unmapped access SHALL return resp=2'b10 (SLVERR) with rdata=0, writes ignored; all other accesses SHALL return 2'b00.
REQ-021 SHALL apply each wstrb bit to its own byte lane; a write with wstrb=0 SHALL change no register.
REQ-022 Map: 0x00 RO SYS_FRE.
REQ-023 Map: 0x04 CTRL: en[0], fifo_clr[8] (self-clearing 1-cycle pulse, reads 0), parity[18:16], data_bit[23:20], stop[26:24].
REQ-024 Map: 0x08 divisor[31:0].
REQ-025 Map: 0x0C TX WO.
REQ-026 Map: 0x10 RX RO = {i_rx_empty, 22'd0, i_rx_data}.
REQ-027 Map: 0x14 {zero-extended tx_cnt[31:16], zero-extended rx_cnt[15:0]}.
REQ-028 Map: 0x18 IRQ_EN[2:0].
REQ-029 Map: 0x1C IRQ_STAT[2:0], write-1-to-clear.
REQ-030 SHALL pulse o_tx_valid for one cycle with wdata[7:0] on a lane-0 TX write when i_tx_full=0; when i_tx_full=1 the byte SHALL be dropped and IRQ_STAT[1] (tx_ovf) set.
REQ-031 SHALL pulse o_rx_req for one cycle on the AR handshake to 0x10 when i_rx_empty=0; when empty, no pop and IRQ_STAT[2] (rx_udf) set.
REQ-032 IRQ_STAT[0] SHALL mirror ~i_rx_empty (level, W1C ignored); sticky set SHALL win over W1C in the same cycle.
REQ-033 o_irq SHALL equal the registered OR of IRQ_STAT & IRQ_EN, one cycle after the status change.

Reset
REQ-034 Asynchronous assertion SHALL force all outputs to 0, except o_fre_cnt=DEF_DIV, o_uart_data_bit=8 and awready/wready/arready=1 after release; transactions in flight SHALL be discarded.

Structure
REQ-035 Package uart_ctrl_pkg SHALL hold register offsets, CTRL field positions, IRQ bit indices and the OKAY/SLVERR codes.
REQ-036 The AXI4-lite handshake FSM SHALL be the sub-module uart_axil_slave, presenting wr_en/addr/data/mask and rd_addr/rd_data to the register bank.

Verification
REQ-037 W before AW: write 0x0080_1234 to 0x08 -> o_fre_cnt=0x0080_1234, bresp=00 exactly once.
REQ-038 wstrb=4'b0100, wdata=0x0075_0000 to 0x04 -> data_bit=7, parity=5, en and stop unchanged.
REQ-039 TX write 0x5A with i_tx_full=1, IRQ_EN=2 -> no tx_valid, IRQ_STAT=0x2, o_irq=1; W1C 0x2 -> o_irq=0.
REQ-040 Read 0x10 with rx not empty (i_rx_data=0x1A5) -> rdata=0x0000_01A5, one rx_req; repeat with empty -> rdata=0x8000_0000, no rx_req, IRQ_STAT[2]=1.
REQ-041 Read 0x40 and 0x100 -> rresp=10, rdata=0.
REQ-042 rready held low 5 cycles -> rvalid and rdata stable, arready=0; reset mid-response -> rvalid=0 asynchronously.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared register map, CTRL field positions, IRQ bit indices and AXI response codes
// for the UART control block.
package uart_ctrl_pkg;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_CTRL     = 8'h04;
  localparam logic [7:0] OFF_DIV      = 8'h08;
  localparam logic [7:0] OFF_TX       = 8'h0C;
  localparam logic [7:0] OFF_RX       = 8'h10;
  localparam logic [7:0] OFF_CNT      = 8'h14;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h18;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h1C;
  localparam logic [5:0] NUM_REGS     = 6'd8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 8;
  localparam int CTRL_PAR  = 16;
  localparam int CTRL_DBIT = 20;
  localparam int CTRL_STOP = 24;
  localparam logic [31:0] CTRL_RW_MASK = 32'h07F7_0001;
  localparam logic [31:0] CTRL_RST     = 32'h0080_0000;

  localparam int IRQ_RX_AVAIL = 0;
  localparam int IRQ_TX_OVF   = 1;
  localparam int IRQ_RX_UDF   = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WS_IDLE, WS_RESP} wr_state_e;
  typedef enum logic {RS_IDLE, RS_DATA} rd_state_e;

  function automatic logic [5:0] reg_idx(input logic [7:0] off);
    return off[7:2];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/uart_axil_slave.sv
// AXI4-lite slave handshake: collects AW/W in any order, issues a single-cycle
// register write, and registers read data/response until the master accepts it.
module uart_axil_slave
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       wr_mask,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  wr_state_e         wst_q, wst_d;
  rd_state_e         rst_q, rst_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    wst_d     = wst_q;
    awready   = !aw_held_q && (wst_q == WS_IDLE);
    wready    = !w_held_q && (wst_q == WS_IDLE);
    wr_en     = (wst_q == WS_IDLE) && aw_held_q && w_held_q;
    if (awvalid && awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (wvalid && wready) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    case (wst_q)
      WS_IDLE: if (wr_en) begin
        wst_d     = WS_RESP;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      WS_RESP: if (bready) wst_d = WS_IDLE;
      default: wst_d = WS_IDLE;
    endcase
  end

  // Read data is sampled at the AR handshake so it stays frozen while rready is low.
  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    arready = (rst_q == RS_IDLE);
    rd_en   = arvalid && arready;
    case (rst_q)
      RS_IDLE: if (rd_en) begin
        rst_d   = RS_DATA;
        rdata_d = rd_err ? 32'd0 : rd_data;
        rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      RS_DATA: if (rready) rst_d = RS_IDLE;
      default: rst_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wst_q     <= WS_IDLE;
      rst_q     <= RS_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bvalid  = (wst_q == WS_RESP);
  assign bresp   = bresp_q;
  assign rvalid  = (rst_q == RS_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign wr_addr = awaddr_q;
  assign wr_data = wdata_q;
  assign wr_mask = lane_mask(wstrb_q);
  assign rd_addr = araddr;

endmodule

// File: rtl/uart_ctrl_axi.sv
// UART control/status register bank behind an AXI4-lite slave: configuration,
// TX push, RX pop, FIFO levels and a level interrupt.
module uart_ctrl_axi
  import uart_ctrl_pkg::*;
#(
  parameter int SYS_FRE = 100_000_000,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 868
) (
  input  logic              i_s_axi_aclk,
  input  logic              i_s_axi_aresetn,
  input  logic [ADDR_W-1:0] i_s_axi_awaddr,
  input  logic              i_s_axi_awvalid,
  output logic              o_s_axi_awready,
  input  logic [31:0]       i_s_axi_wdata,
  input  logic [3:0]        i_s_axi_wstrb,
  input  logic              i_s_axi_wvalid,
  output logic              o_s_axi_wready,
  output logic [1:0]        o_s_axi_bresp,
  output logic              o_s_axi_bvalid,
  input  logic              i_s_axi_bready,
  input  logic [ADDR_W-1:0] i_s_axi_araddr,
  input  logic              i_s_axi_arvalid,
  output logic              o_s_axi_arready,
  output logic [31:0]       o_s_axi_rdata,
  output logic [1:0]        o_s_axi_rresp,
  output logic              o_s_axi_rvalid,
  input  logic              i_s_axi_rready,
  output logic              o_module_en,
  output logic              o_fifo_clr,
  output logic [31:0]       o_fre_cnt,
  output logic [3:0]        o_uart_data_bit,
  output logic [2:0]        o_uart_parity_mode,
  output logic [2:0]        o_uart_stop_bit,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_full,
  input  logic [8:0]        i_rx_data,
  input  logic              i_rx_empty,
  output logic              o_rx_req,
  input  logic [CNT_W-1:0]  i_tx_fifo_wr_cnt,
  input  logic [CNT_W-1:0]  i_rx_fifo_rd_cnt,
  output logic              o_irq
);

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, wr_mask, rd_data;

  logic [31:0] ctrl_q, ctrl_d, div_q, div_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d, rx_req_q, rx_req_d, clr_q, clr_d, irq_q, irq_d;
  logic [2:0]  irq_en_q, irq_en_d, stat_q, stat_d, w1c;
  logic        tx_ovf, rx_udf;

  uart_axil_slave #(.ADDR_W(ADDR_W)) u_axil (
    .clk(i_s_axi_aclk), .rst_n(i_s_axi_aresetn),
    .awaddr(i_s_axi_awaddr), .awvalid(i_s_axi_awvalid), .awready(o_s_axi_awready),
    .wdata(i_s_axi_wdata), .wstrb(i_s_axi_wstrb), .wvalid(i_s_axi_wvalid), .wready(o_s_axi_wready),
    .bresp(o_s_axi_bresp), .bvalid(o_s_axi_bvalid), .bready(i_s_axi_bready),
    .araddr(i_s_axi_araddr), .arvalid(i_s_axi_arvalid), .arready(o_s_axi_arready),
    .rdata(o_s_axi_rdata), .rresp(o_s_axi_rresp), .rvalid(o_s_axi_rvalid), .rready(i_s_axi_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
  );

  // Only the low 8 address bits select a register; anything above must be zero.
  assign wr_err = !(((wr_addr >> 8) == '0) && (wr_addr[7:2] < NUM_REGS));
  assign rd_err = !(((rd_addr >> 8) == '0) && (rd_addr[7:2] < NUM_REGS));

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr[7:2])
      reg_idx(OFF_ID):       rd_data = 32'(SYS_FRE);
      reg_idx(OFF_CTRL):     rd_data = ctrl_q;
      reg_idx(OFF_DIV):      rd_data = div_q;
      reg_idx(OFF_RX):       rd_data = {i_rx_empty, 22'd0, i_rx_data};
      reg_idx(OFF_CNT):      rd_data = {16'(i_tx_fifo_wr_cnt), 16'(i_rx_fifo_rd_cnt)};
      reg_idx(OFF_IRQ_EN):   rd_data = {29'd0, irq_en_q};
      reg_idx(OFF_IRQ_STAT): rd_data = {29'd0, stat_q};
      default:               rd_data = 32'd0;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    tx_data_d  = tx_data_q;
    irq_en_d   = irq_en_q;
    tx_valid_d = 1'b0;
    rx_req_d   = 1'b0;
    clr_d      = 1'b0;
    tx_ovf     = 1'b0;
    rx_udf     = 1'b0;
    w1c        = 3'd0;
    if (wr_en && !wr_err) begin
      case (wr_addr[7:2])
        reg_idx(OFF_CTRL): begin
          ctrl_d = ((ctrl_q & ~wr_mask) | (wr_data & wr_mask)) & CTRL_RW_MASK;
          clr_d  = wr_mask[CTRL_CLR] & wr_data[CTRL_CLR];
        end
        reg_idx(OFF_DIV): div_d = (div_q & ~wr_mask) | (wr_data & wr_mask);
        reg_idx(OFF_TX): if (wr_mask[0]) begin
          if (i_tx_full) tx_ovf = 1'b1;
          else begin
            tx_valid_d = 1'b1;
            tx_data_d  = wr_data[7:0];
          end
        end
        reg_idx(OFF_IRQ_EN):   if (wr_mask[0]) irq_en_d = wr_data[2:0];
        reg_idx(OFF_IRQ_STAT): if (wr_mask[0]) w1c = wr_data[2:0];
        default: ;
      endcase
    end
    if (rd_en && !rd_err && (rd_addr[7:2] == reg_idx(OFF_RX))) begin
      if (i_rx_empty) rx_udf = 1'b1;
      else rx_req_d = 1'b1;
    end
    // A new sticky event in the same cycle as its W1C keeps the bit set.
    stat_d[IRQ_RX_AVAIL] = ~i_rx_empty;
    stat_d[IRQ_TX_OVF]   = (stat_q[IRQ_TX_OVF] & ~w1c[IRQ_TX_OVF]) | tx_ovf;
    stat_d[IRQ_RX_UDF]   = (stat_q[IRQ_RX_UDF] & ~w1c[IRQ_RX_UDF]) | rx_udf;
    irq_d = |(stat_q & irq_en_q);
  end

  always_ff @(posedge i_s_axi_aclk or negedge i_s_axi_aresetn) begin
    if (!i_s_axi_aresetn) begin
      ctrl_q     <= CTRL_RST;
      div_q      <= 32'(DEF_DIV);
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_req_q   <= 1'b0;
      clr_q      <= 1'b0;
      irq_en_q   <= '0;
      stat_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_req_q   <= rx_req_d;
      clr_q      <= clr_d;
      irq_en_q   <= irq_en_d;
      stat_q     <= stat_d;
      irq_q      <= irq_d;
    end
  end

  assign o_module_en        = ctrl_q[CTRL_EN];
  assign o_fifo_clr         = clr_q;
  assign o_fre_cnt          = div_q;
  assign o_uart_data_bit    = ctrl_q[CTRL_DBIT +: 4];
  assign o_uart_parity_mode = ctrl_q[CTRL_PAR +: 3];
  assign o_uart_stop_bit    = ctrl_q[CTRL_STOP +: 3];
  assign o_tx_data          = tx_data_q;
  assign o_tx_valid         = tx_valid_q;
  assign o_rx_req           = rx_req_q;
  assign o_irq              = irq_q;

endmodule
